// File: rtl/rv32i_trap_pkg.sv
// Shared types and helpers for the RV32I machine-mode trap controller.
package rv32i_trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    RETURN   = 2'd3
  } state_t;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;
  localparam int         MCAUSE_IRQ_BIT = 31;

  function automatic logic [31:0] build_mcause(input logic is_irq, input logic [30:0] code);
    logic [31:0] m;
    m = {1'b0, code};
    m[MCAUSE_IRQ_BIT] = is_irq;
    return m;
  endfunction

endpackage

// File: rtl/rv32i_irq_priority_encoder.sv
// Fixed-priority encoder over the masked interrupt requests; lowest index wins.
module rv32i_irq_priority_encoder #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               any_valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan downward so the last hit recorded is the lowest set index.
  always_comb begin
    any_valid = 1'b0;
    idx       = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_valid = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rv32i_trap_controller.sv
// Machine-mode trap entry/return sequencer: arbitrates exceptions, mret and
// interrupts, latches mepc/mcause, flushes the pipeline and redirects fetch.
module rv32i_trap_controller
  import rv32i_trap_pkg::*;
#(
  parameter int NUM_IRQ        = 8,
  parameter int FLUSH_CYCLES   = 2,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [3:0]         exc_code,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        commit_pc,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [31:0]        mtvec,
  input  logic               mret,
  input  logic               gie_wr_en,
  input  logic               gie_wr_data,
  output logic               flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        mepc,
  output logic [31:0]        mcause,
  output logic               gie,
  output logic               mpie,
  output logic               busy,
  output logic               trap_taken
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        gie_q, gie_d;
  logic        mpie_q, mpie_d;

  logic [NUM_IRQ-1:0] irq_masked;
  logic               irq_any;
  logic [IDX_W-1:0]   irq_idx;
  logic [30:0]        irq_cause;
  logic [31:0]        vec_base;

  assign irq_masked = irq_pending & irq_enable;

  rv32i_irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio (
    .req       (irq_masked),
    .any_valid (irq_any),
    .idx       (irq_idx)
  );

  assign irq_cause = 31'(IRQ_CAUSE_BASE) + 31'(irq_idx);
  assign vec_base  = {mtvec[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;
    gie_d         = gie_q;
    mpie_d        = mpie_q;

    case (state_q)
      IDLE: begin
        // Software write first so a same-cycle trap/mret decision overrides it.
        if (gie_wr_en) gie_d = gie_wr_data;
        if (exc_valid) begin
          state_d       = FLUSH;
          cnt_d         = 4'(FLUSH_CYCLES - 1);
          mepc_d        = exc_pc;
          mcause_d      = build_mcause(1'b0, 31'(exc_code));
          redirect_pc_d = vec_base;
          mpie_d        = gie_q;
          gie_d         = 1'b0;
        end else if (mret) begin
          state_d       = RETURN;
          redirect_pc_d = mepc_q;
          gie_d         = mpie_q;
          mpie_d        = 1'b1;
        end else if (gie_q && irq_any) begin
          state_d  = FLUSH;
          cnt_d    = 4'(FLUSH_CYCLES - 1);
          mepc_d   = commit_pc;
          mcause_d = build_mcause(1'b1, irq_cause);
          mpie_d   = gie_q;
          gie_d    = 1'b0;
          if (mtvec[1:0] == MTVEC_VECTORED)
            redirect_pc_d = vec_base + (32'(irq_cause) << 2);
          else
            redirect_pc_d = vec_base;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      RETURN: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
      gie_q         <= 1'b0;
      mpie_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_pc_q <= redirect_pc_d;
      gie_q         <= gie_d;
      mpie_q        <= mpie_d;
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign flush          = (state_q == FLUSH);
  assign redirect_valid = (state_q == REDIRECT) || (state_q == RETURN);
  assign busy           = (state_q != IDLE);
  assign trap_taken     = (state_q == REDIRECT) && redirect_ready;
  assign redirect_pc    = redirect_pc_q;
  assign mepc           = mepc_q;
  assign mcause         = mcause_q;
  assign gie            = gie_q;
  assign mpie           = mpie_q;

endmodule

// File: tb/tb_rv32i_trap_controller.sv
// Directed self-checking bench for rv32i_trap_controller.
module tb_rv32i_trap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] commit_pc;
  logic [7:0]  irq_pending;
  logic [7:0]  irq_enable;
  logic [31:0] mtvec;
  logic        mret;
  logic        gie_wr_en;
  logic        gie_wr_data;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic        gie;
  logic        mpie;
  logic        busy;
  logic        trap_taken;

  int n_checks = 0;
  int n_errors = 0;
  logic prev_busy = 1'b0;

  always #5 clk = ~clk;

  rv32i_trap_controller #(
    .NUM_IRQ        (8),
    .FLUSH_CYCLES   (2),
    .IRQ_CAUSE_BASE (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_pc         (exc_pc),
    .commit_pc      (commit_pc),
    .irq_pending    (irq_pending),
    .irq_enable     (irq_enable),
    .mtvec          (mtvec),
    .mret           (mret),
    .gie_wr_en      (gie_wr_en),
    .gie_wr_data    (gie_wr_data),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .mepc           (mepc),
    .mcause         (mcause),
    .gie            (gie),
    .mpie           (mpie),
    .busy           (busy),
    .trap_taken     (trap_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exc_valid must stay low while busy, except in the first FLUSH cycle.
  always @(negedge clk) begin
    if (!rst && busy && prev_busy)
      check("exc_while_busy", {31'd0, exc_valid}, 32'd0);
    prev_busy <= busy && !rst;
  end

  initial begin
    logic [31:0] held_pc;
    rst = 1'b1;
    exc_valid = 0; exc_code = 0; exc_pc = 0; commit_pc = 0;
    irq_pending = 0; irq_enable = 0; mtvec = 0; mret = 0;
    gie_wr_en = 0; gie_wr_data = 0; redirect_ready = 0;
    step(); step();

    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("rst_gie", {31'd0, gie}, 32'd0);
    check("rst_mpie", {31'd0, mpie}, 32'd1);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mcause", mcause, 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    rst = 1'b0;
    step();

    // Exception with vectored mtvec; vectoring must not apply.
    exc_valid = 1; exc_code = 4'd2; exc_pc = 32'h100; mtvec = 32'h8000_0001;
    step();
    exc_valid = 0;
    check("exc_mepc", mepc, 32'h100);
    check("exc_mcause", mcause, 32'h0000_0002);
    check("exc_flush1", {31'd0, flush}, 32'd1);
    check("exc_gie", {31'd0, gie}, 32'd0);
    check("exc_mpie", {31'd0, mpie}, 32'd0);
    step();
    check("exc_flush2", {31'd0, flush}, 32'd1);
    check("exc_rvalid_in_flush", {31'd0, redirect_valid}, 32'd0);
    step();
    check("exc_flush_done", {31'd0, flush}, 32'd0);
    check("exc_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("exc_rpc", redirect_pc, 32'h8000_0000);
    held_pc = redirect_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rvalid", {31'd0, redirect_valid}, 32'd1);
      check("bp_rpc", redirect_pc, 32'h8000_0000);
      check("bp_no_taken", {31'd0, trap_taken}, 32'd0);
    end
    redirect_ready = 1;
    #1;
    check("bp_taken", {31'd0, trap_taken}, 32'd1);
    step();
    redirect_ready = 0;
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("bp_taken_gone", {31'd0, trap_taken}, 32'd0);

    // Enable gie together with pending IRQs: not taken in the write cycle.
    gie_wr_en = 1; gie_wr_data = 1;
    irq_pending = 8'h0C; irq_enable = 8'hFF; commit_pc = 32'h200;
    #1;
    check("irq_wr_cycle_idle", {31'd0, busy}, 32'd0);
    step();
    gie_wr_en = 0;
    check("irq_gie_set", {31'd0, gie}, 32'd1);
    check("irq_not_same_cycle", {31'd0, busy}, 32'd0);
    step();
    irq_pending = 0;
    check("irq_mepc", mepc, 32'h200);
    check("irq_mcause", mcause, 32'h8000_0012);
    check("irq_gie", {31'd0, gie}, 32'd0);
    check("irq_mpie", {31'd0, mpie}, 32'd1);
    step(); step();
    check("irq_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("irq_rpc", redirect_pc, 32'h8000_0048);
    redirect_ready = 1;
    #1;
    check("irq_taken", {31'd0, trap_taken}, 32'd1);
    step();
    redirect_ready = 0;

    // Re-enable gie, then mret with an interrupt pending in the same cycle.
    gie_wr_en = 1; gie_wr_data = 1;
    step();
    gie_wr_en = 0;
    mret = 1; irq_pending = 8'h01;
    step();
    mret = 0; irq_pending = 0;
    check("mret_busy", {31'd0, busy}, 32'd1);
    check("mret_no_flush", {31'd0, flush}, 32'd0);
    check("mret_rvalid", {31'd0, redirect_valid}, 32'd1);
    check("mret_rpc", redirect_pc, 32'h200);
    check("mret_gie", {31'd0, gie}, 32'd1);
    check("mret_mpie", {31'd0, mpie}, 32'd1);
    check("mret_mcause_kept", mcause, 32'h8000_0012);
    redirect_ready = 1;
    #1;
    check("mret_no_taken", {31'd0, trap_taken}, 32'd0);
    step();
    redirect_ready = 0;
    check("mret_idle", {31'd0, busy}, 32'd0);

    // Exception and interrupt together: exception wins.
    exc_valid = 1; exc_code = 4'd5; exc_pc = 32'h300; irq_pending = 8'h01;
    step();
    exc_valid = 0; irq_pending = 0;
    check("both_mcause", mcause, 32'h0000_0005);
    check("both_mepc", mepc, 32'h300);
    check("both_flush", {31'd0, flush}, 32'd1);

    // Asynchronous reset in the middle of FLUSH.
    #2;
    rst = 1;
    #1;
    check("rst_mid_flush", {31'd0, flush}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_rvalid", {31'd0, redirect_valid}, 32'd0);
    check("rst_mid_gie", {31'd0, gie}, 32'd0);
    check("rst_mid_mpie", {31'd0, mpie}, 32'd1);
    check("rst_mid_mepc", mepc, 32'd0);
    step();
    rst = 0;
    step();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rv32i_trap_controller.md
Name:
rv32i_trap_controller

Overview:
- Sequences machine-mode trap entry and return for the RV32I core.
- Arbitrates between a synchronous pipeline exception and NUM_IRQ level-sensitive interrupt lines, then latches mepc/mcause.
- Drives a pipeline flush for a fixed number of cycles, then hands the trap-vector target PC to fetch through a valid/ready redirect handshake.
- Handles mret by restoring the interrupt-enable stack and redirecting to mepc.

Parameters:
- NUM_IRQ, 8, number of external interrupt request lines (1..16).
- FLUSH_CYCLES, 2, cycles flush is held asserted before redirect (1..15).
- IRQ_CAUSE_BASE, 16, mcause code of irq_pending[0]; line i maps to code IRQ_CAUSE_BASE+i.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- exc_valid  in  1  synchronous exception reported by the pipeline this cycle.
- exc_code  in  4  exception cause code.
- exc_pc  in  32  PC of the faulting instruction.
- commit_pc  in  32  PC of the next instruction to commit; this becomes mepc for interrupts.
- irq_pending  in  NUM_IRQ  level interrupt requests.
- irq_enable  in  NUM_IRQ  per-line enable mask (mie).
- mtvec  in  32  trap vector; bits[1:0]: 0 = direct, 1 = vectored.
- mret  in  1  mret retiring this cycle.
- gie_wr_en  in  1  software write of the global interrupt enable bit.
- gie_wr_data  in  1  value for that write.
- flush  out  1  kill all in-flight pipeline instructions.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_ready  in  1  fetch accepts the redirect.
- redirect_pc  out  32  new fetch PC.
- mepc  out  32  machine exception PC.
- mcause  out  32  bit31 = interrupt flag, bits[30:0] = cause code.
- gie  out  1  global interrupt enable (mstatus.MIE).
- mpie  out  1  previous interrupt enable (mstatus.MPIE).
- busy  out  1  FSM is not in IDLE.
- trap_taken  out  1  one-cycle pulse on the redirect handshake of trap entry.

Behaviour:
- Reset values (asynchronous): state IDLE; flush, redirect_valid, busy, trap_taken, gie = 0; mpie = 1; mepc, mcause, redirect_pc = 0; flush counter = 0. Reset mid-operation aborts everything immediately.
- States: IDLE, FLUSH, REDIRECT, RETURN.
- Arbitration, evaluated in IDLE only:
  - exc_valid has highest priority.
  - mret is next.
  - An interrupt is taken only if gie=1 and (irq_pending & irq_enable) != 0. Among eligible lines, the lowest index wins.
- Trap entry, decided in IDLE at cycle N; all updates land at the N+1 edge:
  - State goes to FLUSH and the counter loads FLUSH_CYCLES-1.
  - mepc = exc_pc for an exception, commit_pc for an interrupt.
  - mcause = {1'b0, 27'b0, exc_code} for an exception; {1'b1, 31'(IRQ_CAUSE_BASE+idx)} for an interrupt.
  - mpie <= gie, gie <= 0.
  - redirect_pc = {mtvec[31:2], 2'b00}. For an interrupt with mtvec[1:0]==1, add 4*cause code; arithmetic is 32-bit and wraps.
- FLUSH: flush=1 every cycle; the counter decrements. At counter 0, go to REDIRECT. flush is high for exactly FLUSH_CYCLES cycles.
- REDIRECT: redirect_valid=1 and redirect_pc held stable until redirect_ready=1. That cycle pulses trap_taken and returns to IDLE on the next edge. There is no timeout; redirect_valid, once raised, must not drop until the handshake completes.
- mret in IDLE, with no exc_valid:
  - State goes to RETURN; redirect_pc <= mepc; gie <= mpie; mpie <= 1.
  - RETURN holds redirect_valid=1 until redirect_ready, then returns to IDLE.
  - RETURN asserts no flush and no trap_taken.
- busy=1 in every state except IDLE.
- Outside IDLE, exc_valid, mret and interrupts are ignored; the pipeline is being flushed. A bench assertion flags exc_valid while busy, except during the first FLUSH cycle.
- gie_wr_en is honoured only in IDLE. In the same cycle as a trap or mret decision, the FSM's update of gie wins over the software write. A write that enables gie takes effect the next cycle, so an interrupt cannot be taken in the same cycle as the write.
- mcause and mepc change only on trap entry.

Decomposition:
- Package rv32i_trap_pkg holds:
  - state_t enum {IDLE, FLUSH, REDIRECT, RETURN};
  - MTVEC_DIRECT = 2'd0 and MTVEC_VECTORED = 2'd1;
  - MCAUSE_IRQ_BIT = 31;
  - a function building mcause from (is_irq, code).
- Sub-module rv32i_irq_priority_encoder: combinational, with parameter NUM_IRQ. Input is the masked request vector; outputs are any_valid and the winning index ($clog2(NUM_IRQ) bits, lowest index wins).

Test Plan:
- Exception: exc_valid=1, exc_code=2, exc_pc=0x100, mtvec=0x8000_0001.
  - Required: mepc=0x100 and mcause=0x0000_0002 at N+1; flush high for 2 cycles.
  - Then redirect_pc=0x8000_0000 (vectoring is ignored for exceptions); gie=0.
- Vectored interrupt: gie=1, irq_pending=0x0C, irq_enable=0xFF, commit_pc=0x200, mtvec=0x8000_0001.
  - Required: line 2 wins; mcause=0x8000_0012; mepc=0x200; redirect_pc=0x8000_0048.
- Simultaneous exception and interrupt: exc_valid and an enabled interrupt in the same cycle -> the exception is taken and mcause bit31=0.
- Backpressure: redirect_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stay stable. trap_taken pulses once, on the ready cycle, and the FSM returns to IDLE.
- mret: in IDLE with mepc=0x200 and mpie=1 -> redirect_pc=0x200, gie=1, mpie=1, no flush. A pending interrupt in the mret cycle is not taken.
- Reset mid-trap: assert rst during FLUSH -> flush, redirect_valid and busy drop immediately; gie=0, mpie=1, mepc=0.
